// File: rtl/xor_encrypt_pkg.sv
// Purpose: shared types for the XOR encryption pipeline (word and mixed-word records).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package xor_encrypt_pkg;

    localparam int DATA_W = 32;
    // Key-index field is sized for the largest supported key file (16 keys).
    localparam int KIDX_W = 4;

    typedef logic [DATA_W-1:0] word_t;

    typedef struct packed {
        word_t             data;
        logic [KIDX_W-1:0] kidx;
    } mixed_t;

endpackage

// File: rtl/key_mix_skid.sv
// Purpose: generic 2-entry valid/ready skid buffer (main = output register, skid = overflow).
// Latency: 1 cycle from accept to out_valid when main is empty or draining.
// Backpressure: in_ready is registered (!skid full); no combinational path from out_ready.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_valid/in_ready     upstream handshake, in_data payload of type T
//   out_valid/out_ready   downstream handshake, out_data payload of type T
module key_mix_skid
    import xor_encrypt_pkg::*;
#(
    parameter type T = mixed_t
) (
    input  logic clk,
    input  logic rst,
    input  logic in_valid,
    output logic in_ready,
    input  T     in_data,
    output logic out_valid,
    input  logic out_ready,
    output T     out_data
);

    logic main_vld;
    logic skid_vld;
    logic rdy_q;
    T     main_q;
    T     skid_q;

    logic push;
    logic load_main;
    logic skid_nxt;

    assign push      = in_valid && rdy_q;
    // Main can take a new value when it is empty or its contents leave this cycle.
    assign load_main = !main_vld || out_ready;
    // Skid empties whenever main reloads (skid has priority); otherwise it
    // captures a word pushed while main is held. A push with skid full cannot
    // happen because in_ready is already low.
    assign skid_nxt  = load_main ? 1'b0 : (skid_vld || push);

    always_ff @(posedge clk) begin
        if (rst) begin
            main_vld <= 1'b0;
            skid_vld <= 1'b0;
            rdy_q    <= 1'b0;
            main_q   <= '0;
            skid_q   <= '0;
        end else begin
            if (load_main) begin
                if (skid_vld) begin
                    main_q   <= skid_q;
                    main_vld <= 1'b1;
                end else begin
                    main_vld <= push;
                    if (push) begin
                        main_q <= in_data;
                    end
                end
            end else if (push) begin
                skid_q <= in_data;
            end
            skid_vld <= skid_nxt;
            rdy_q    <= !skid_nxt;
        end
    end

    assign in_ready  = rdy_q;
    assign out_valid = main_vld;
    assign out_data  = main_q;

endmodule

// File: rtl/layer11_key_mix.sv
// Purpose: XOR each accepted word with a rotating programmable round key (in_sop restarts at key 0).
// Latency: 1 cycle accept-to-output when the output register is free; 1 word/cycle sustained.
// Backpressure: 2-entry skid; in_ready drops the cycle after the second word is held.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset (clears keys and buffers)
//   key_we, key_idx, key_data      key file write port, effective at the edge
//   in_valid, in_ready, in_data,
//   in_sop                         upstream word stream; in_sop forces key index 0
//   out_valid, out_ready, out_data,
//   out_key_idx                    mixed word stream and the key index applied to it
module layer11_key_mix
    import xor_encrypt_pkg::*;
#(
    parameter  int NUM_KEYS  = 4,
    localparam int KEY_IDX_W = $clog2(NUM_KEYS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 key_we,
    input  logic [KEY_IDX_W-1:0] key_idx,
    input  logic [31:0]          key_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_data,
    input  logic                 in_sop,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_data,
    output logic [KEY_IDX_W-1:0] out_key_idx
);

    word_t                keys [NUM_KEYS];
    logic [KEY_IDX_W-1:0] kptr;
    logic [KEY_IDX_W-1:0] used;
    logic                 accept;
    mixed_t               mix_in;
    mixed_t               mix_out;
    logic                 unused_kidx;

    assign accept = in_valid && in_ready;
    assign used   = in_sop ? '0 : kptr;

    // Reads see the pre-edge key, so a same-cycle write to the used slot
    // only affects later words.
    always_comb begin
        mix_in      = '0;
        mix_in.data = in_data ^ keys[used];
        mix_in.kidx = KIDX_W'(used);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            kptr <= '0;
            for (int i = 0; i < NUM_KEYS; i++) begin
                keys[i] <= '0;
            end
        end else begin
            if (accept) begin
                kptr <= (used == KEY_IDX_W'(NUM_KEYS - 1)) ? '0 : used + KEY_IDX_W'(1);
            end
            if (key_we) begin
                keys[key_idx] <= key_data;
            end
        end
    end

    key_mix_skid #(
        .T (mixed_t)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (mix_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (mix_out)
    );

    assign out_data    = mix_out.data;
    assign out_key_idx = mix_out.kidx[KEY_IDX_W-1:0];
    // Upper index bits are always zero for smaller key files.
    assign unused_kidx = ^mix_out.kidx;

endmodule

// File: tb/tb_layer11_key_mix.sv
module tb_layer11_key_mix;

    logic        clk;
    logic        rst;
    logic        key_we;
    logic [1:0]  key_idx;
    logic [31:0] key_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_sop;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [1:0]  out_key_idx;

    int n_cmp = 0;
    int n_bad = 0;

    layer11_key_mix #(.NUM_KEYS(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .key_we      (key_we),
        .key_idx     (key_idx),
        .key_data    (key_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_sop      (in_sop),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_key_idx (out_key_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] din;
        logic        sop;
        logic [31:0] dout;
        logic [31:0] kidx;
    } vec_t;

    vec_t vt [9];

    logic [31:0] mkeys [4];
    int          mk;
    logic [35:0] q [$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic write_key(input int idx, input logic [31:0] val);
        key_we   = 1'b1;
        key_idx  = 2'(idx);
        key_data = val;
        tick();
        key_we   = 1'b0;
    endtask

    initial begin
        int acc;
        int cyc;
        int u;
        logic hold;
        logic [31:0] hold_dat;
        logic [35:0] e;

        // Rotation and mid-block sop vectors, keys 11../22../44../88..
        vt[0] = '{32'h0000_0000, 1'b1, 32'h1111_1111, 0};
        vt[1] = '{32'h0000_0000, 1'b0, 32'h2222_2222, 1};
        vt[2] = '{32'h0000_0000, 1'b0, 32'h4444_4444, 2};
        vt[3] = '{32'h0000_0000, 1'b0, 32'h8888_8888, 3};
        vt[4] = '{32'h0000_0000, 1'b0, 32'h1111_1111, 0};
        vt[5] = '{32'h0000_00A0, 1'b0, 32'h2222_2282, 1};
        vt[6] = '{32'h0000_00B0, 1'b0, 32'h4444_44F4, 2};
        vt[7] = '{32'h0000_00C0, 1'b1, 32'h1111_11D1, 0};
        vt[8] = '{32'h0000_00D0, 1'b0, 32'h2222_22F2, 1};

        rst = 1'b1; key_we = 1'b0; key_idx = '0; key_data = '0;
        in_valid = 1'b0; in_data = '0; in_sop = 1'b0; out_ready = 1'b0;
        tick(); tick(); tick();

        chk("rst_in_ready",  32'(in_ready),    32'd0);
        chk("rst_out_valid", 32'(out_valid),   32'd0);
        chk("rst_out_data",  out_data,         32'd0);
        chk("rst_out_kidx",  32'(out_key_idx), 32'd0);
        rst = 1'b0;
        tick();
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        write_key(0, 32'h1111_1111);
        write_key(1, 32'h2222_2222);
        write_key(2, 32'h4444_4444);
        write_key(3, 32'h8888_8888);

        // Streaming table: one word per cycle, each visible right after its accept edge.
        out_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            in_valid = 1'b1;
            in_data  = vt[i].din;
            in_sop   = vt[i].sop;
            tick();
            chk($sformatf("vec%0d_valid", i), 32'(out_valid),   32'd1);
            chk($sformatf("vec%0d_data", i),  out_data,         vt[i].dout);
            chk($sformatf("vec%0d_kidx", i),  32'(out_key_idx), vt[i].kidx);
        end
        in_valid = 1'b0; in_sop = 1'b0;
        tick();
        chk("stream_drained", 32'(out_valid), 32'd0);

        // Backpressure: two words held, in_ready falls, then recovery.
        write_key(0, 32'h0000_0000);
        out_ready = 1'b0;
        in_valid = 1'b1; in_sop = 1'b1; in_data = 32'hDEAD_BEEF;
        tick();
        chk("bp_rdy_after_first", 32'(in_ready), 32'd1);
        in_data = 32'hCAFE_F00D;
        tick();
        chk("bp_rdy_after_second", 32'(in_ready), 32'd0);
        chk("bp_hold_data",        out_data,      32'hDEAD_BEEF);
        in_valid = 1'b0; in_sop = 1'b0;
        tick(); tick();
        chk("bp_still_valid", 32'(out_valid), 32'd1);
        chk("bp_still_data",  out_data,       32'hDEAD_BEEF);
        chk("bp_still_rdy",   32'(in_ready),  32'd0);
        out_ready = 1'b1;
        tick();
        chk("bp_second_valid", 32'(out_valid), 32'd1);
        chk("bp_second_data",  out_data,       32'hCAFE_F00D);
        chk("bp_rdy_recover",  32'(in_ready),  32'd1);
        tick();
        chk("bp_empty", 32'(out_valid), 32'd0);

        // Key write collides with an accept that reads the same slot.
        key_we = 1'b1; key_idx = 2'd0; key_data = 32'hFFFF_FFFF;
        in_valid = 1'b1; in_sop = 1'b1; in_data = 32'h1234_5678;
        tick();
        key_we = 1'b0;
        chk("coll_old_key", out_data, 32'h1234_5678);
        tick();
        chk("coll_new_key",  out_data,         32'hEDCB_A987);
        chk("coll_new_kidx", 32'(out_key_idx), 32'd0);

        // Reset mid-stream with two buffered words and a same-cycle key write.
        out_ready = 1'b0; in_sop = 1'b0;
        in_data = 32'h0101_0101; tick();
        in_data = 32'h0202_0202; tick();
        chk("mid_buffered", 32'(out_valid), 32'd1);
        in_valid = 1'b0;
        rst = 1'b1;
        key_we = 1'b1; key_idx = 2'd0; key_data = 32'hFFFF_0000;
        tick();
        key_we = 1'b0;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_data",  out_data,       32'd0);
        chk("mid_rst_rdy",   32'(in_ready),  32'd0);
        rst = 1'b0;
        tick();
        chk("mid_post_rdy", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        in_valid = 1'b1; in_sop = 1'b0; in_data = 32'h5A5A_5A5A;
        tick();
        in_valid = 1'b0;
        chk("mid_first_data", out_data,         32'h5A5A_5A5A);
        chk("mid_first_kidx", 32'(out_key_idx), 32'd0);

        // Random soak against a reference model from a clean reset.
        rst = 1'b1; tick(); rst = 1'b0; tick();
        for (int i = 0; i < 4; i++) mkeys[i] = '0;
        mk = 0;
        acc = 0; cyc = 0; hold = 1'b0; hold_dat = '0;
        while (acc < 10000 && cyc < 60000) begin
            if (hold) begin
                chk("soak_hold_valid", 32'(out_valid), 32'd1);
                chk("soak_hold_data",  out_data,       hold_dat);
            end
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = $urandom;
            in_sop    = ($urandom_range(0, 7) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            key_we    = ($urandom_range(0, 31) == 0);
            key_idx   = 2'($urandom_range(0, 3));
            key_data  = $urandom;
            if (in_valid && in_ready) begin
                u = in_sop ? 0 : mk;
                q.push_back({in_data ^ mkeys[u], 4'(u)});
                mk = (u == 3) ? 0 : u + 1;
                acc++;
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL soak_extra_word: got %h want none", out_data);
                end else begin
                    e = q.pop_front();
                    chk("soak_data", out_data,         e[35:4]);
                    chk("soak_kidx", 32'(out_key_idx), 32'(e[3:0]));
                end
            end
            if (key_we) mkeys[key_idx] = key_data;
            hold     = out_valid && !out_ready;
            hold_dat = out_data;
            cyc++;
            tick();
        end
        if (acc < 10000) begin
            n_cmp++; n_bad++;
            $display("FAIL soak_timeout: got %0d words want 10000", acc);
        end

        in_valid = 1'b0; key_we = 1'b0; out_ready = 1'b1;
        cyc = 0;
        while (q.size() > 0 && cyc < 100) begin
            if (out_valid) begin
                e = q.pop_front();
                chk("drain_data", out_data,         e[35:4]);
                chk("drain_kidx", 32'(out_key_idx), 32'(e[3:0]));
            end
            cyc++;
            tick();
        end
        chk("drain_left",  32'(q.size()),   32'd0);
        chk("drain_valid", 32'(out_valid),  32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
